// File: rtl/ov7670_fb_pkg.sv
// Shared types and reset constants for the OV7670 triple-buffer scheduler.
// Three buffers are always split between writer, ready slot and reader.
package ov7670_fb_pkg;

  typedef logic [1:0] buf_idx_t;

  localparam int       NUM_BUFS    = 3;
  localparam buf_idx_t RST_WR_IDX  = 2'd0;
  localparam buf_idx_t RST_RDY_IDX = 2'd1;
  localparam buf_idx_t RST_RD_IDX  = 2'd2;

  // With a, b distinct in 0..2 the third index is 3-a-b; 2-bit wrap is harmless.
  function automatic buf_idx_t free_idx(buf_idx_t a, buf_idx_t b);
    return 2'd3 - a - b;
  endfunction

endpackage

// File: rtl/ov7670_triple_buffer_scheduler_rise_edge_detect.sv
// Rising-edge detector: rise is high in the first cycle sig is sampled high.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/ov7670_triple_buffer_scheduler.sv
// Triple-buffer scheduler between OV7670 capture and VGA display: publishes only
// complete frames, keeps writer/ready/reader buffer indices pairwise distinct.
module ov7670_triple_buffer_scheduler
  import ov7670_fb_pkg::*;
#(
  parameter  int H_PIXELS   = 160,
  parameter  int V_PIXELS   = 120,
  parameter  int FRAME_SIZE = H_PIXELS * V_PIXELS,
  parameter  int CNT_W      = 16,
  localparam int ADDR_W     = $clog2(3 * FRAME_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              wr_we,
  input  logic              vga_vsync,
  output logic [1:0]        wr_buf_sel,
  output logic [1:0]        rd_buf_sel,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] rd_base,
  output logic              ready_valid,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);

  localparam int             PIX_W    = $clog2(FRAME_SIZE + 2);
  localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(FRAME_SIZE);
  localparam logic [PIX_W-1:0] PIX_SAT  = PIX_W'(FRAME_SIZE + 1);

  function automatic logic [ADDR_W-1:0] base_of(buf_idx_t idx);
    return ADDR_W'(idx) * ADDR_W'(FRAME_SIZE);
  endfunction

  logic cam_rise;
  logic vga_rise;

  rise_edge_detect u_cam_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (cam_vsync),
    .rise  (cam_rise)
  );

  rise_edge_detect u_vga_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (vga_vsync),
    .rise  (vga_rise)
  );

  buf_idx_t          wr_buf_sel_q, wr_buf_sel_d;
  buf_idx_t          ready_idx_q, ready_idx_d;
  buf_idx_t          rd_buf_sel_q, rd_buf_sel_d;
  logic              ready_valid_q, ready_valid_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  repeat_cnt_q, repeat_cnt_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;

  logic [PIX_W-1:0]  pix_inc;
  logic              frame_done;

  always_comb begin
    pix_inc       = pix_cnt_q;
    wr_buf_sel_d  = wr_buf_sel_q;
    ready_idx_d   = ready_idx_q;
    rd_buf_sel_d  = rd_buf_sel_q;
    ready_valid_d = ready_valid_q;
    drop_cnt_d    = drop_cnt_q;
    repeat_cnt_d  = repeat_cnt_q;

    // A write coincident with the closing vsync still belongs to that frame.
    if (wr_we && (pix_cnt_q != PIX_SAT)) begin
      pix_inc = pix_cnt_q + 1'b1;
    end
    frame_done = cam_rise && (pix_inc == PIX_FULL);
    pix_cnt_d  = cam_rise ? '0 : pix_inc;

    // Reader is served first from the pre-cycle ready slot.
    if (vga_rise) begin
      if (ready_valid_q) begin
        rd_buf_sel_d  = ready_idx_q;
        ready_idx_d   = rd_buf_sel_q;
        ready_valid_d = 1'b0;
      end else if (repeat_cnt_q != '1) begin
        repeat_cnt_d = repeat_cnt_q + 1'b1;
      end
    end

    if (frame_done) begin
      ready_idx_d   = wr_buf_sel_q;
      ready_valid_d = 1'b1;
      wr_buf_sel_d  = free_idx(rd_buf_sel_d, wr_buf_sel_q);
    end else if (cam_rise && (pix_inc != '0) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    wr_base_d = base_of(wr_buf_sel_d);
    rd_base_d = base_of(rd_buf_sel_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_buf_sel_q  <= RST_WR_IDX;
      ready_idx_q   <= RST_RDY_IDX;
      rd_buf_sel_q  <= RST_RD_IDX;
      ready_valid_q <= 1'b0;
      pix_cnt_q     <= '0;
      drop_cnt_q    <= '0;
      repeat_cnt_q  <= '0;
      wr_base_q     <= base_of(RST_WR_IDX);
      rd_base_q     <= base_of(RST_RD_IDX);
    end else begin
      wr_buf_sel_q  <= wr_buf_sel_d;
      ready_idx_q   <= ready_idx_d;
      rd_buf_sel_q  <= rd_buf_sel_d;
      ready_valid_q <= ready_valid_d;
      pix_cnt_q     <= pix_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      repeat_cnt_q  <= repeat_cnt_d;
      wr_base_q     <= wr_base_d;
      rd_base_q     <= rd_base_d;
    end
  end

  assign wr_buf_sel  = wr_buf_sel_q;
  assign rd_buf_sel  = rd_buf_sel_q;
  assign wr_base     = wr_base_q;
  assign rd_base     = rd_base_q;
  assign ready_valid = ready_valid_q;
  assign drop_cnt    = drop_cnt_q;
  assign repeat_cnt  = repeat_cnt_q;

  a_idx_legal : assert property (@(posedge clk) disable iff (reset)
    (int'(wr_buf_sel_q) < NUM_BUFS) && (int'(ready_idx_q) < NUM_BUFS) &&
    (int'(rd_buf_sel_q) < NUM_BUFS) && (wr_buf_sel_q != ready_idx_q) &&
    (wr_buf_sel_q != rd_buf_sel_q) && (ready_idx_q != rd_buf_sel_q));

endmodule

// File: tb/tb_ov7670_triple_buffer_scheduler.sv
// Bench: full-size instance for directed QQVGA scenarios, small-frame instance
// for randomized frames, both checked against a buffer-ownership model.
module tb_ov7670_triple_buffer_scheduler;

  localparam int FS_B = 19200;
  localparam int AW_B = $clog2(3 * FS_B);
  localparam int FS_S = 12;
  localparam int AW_S = $clog2(3 * FS_S);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // full-size instance
  logic            rst_b, cam_b, we_b, vga_b;
  logic [1:0]      wr_b, rd_b;
  logic [AW_B-1:0] wrbase_b, rdbase_b;
  logic            valid_b;
  logic [15:0]     drop_b, rep_b;

  // small-frame instance
  logic            rst_s, cam_s, we_s, vga_s;
  logic [1:0]      wr_s, rd_s;
  logic [AW_S-1:0] wrbase_s, rdbase_s;
  logic            valid_s;
  logic [15:0]     drop_s, rep_s;

  ov7670_triple_buffer_scheduler dut_b (
    .clk(clk), .reset(rst_b), .cam_vsync(cam_b), .wr_we(we_b), .vga_vsync(vga_b),
    .wr_buf_sel(wr_b), .rd_buf_sel(rd_b), .wr_base(wrbase_b), .rd_base(rdbase_b),
    .ready_valid(valid_b), .drop_cnt(drop_b), .repeat_cnt(rep_b)
  );

  ov7670_triple_buffer_scheduler #(.H_PIXELS(4), .V_PIXELS(3)) dut_s (
    .clk(clk), .reset(rst_s), .cam_vsync(cam_s), .wr_we(we_s), .vga_vsync(vga_s),
    .wr_buf_sel(wr_s), .rd_buf_sel(rd_s), .wr_base(wrbase_s), .rd_base(rdbase_s),
    .ready_valid(valid_s), .drop_cnt(drop_s), .repeat_cnt(rep_s)
  );

  // Model: which buffer each party owns, plus frame bookkeeping.
  typedef struct {
    int wr, rdy, rd;
    bit valid;
    int pix, drop, rep;
    bit cam_p, vga_p;
  } model_t;

  model_t mb, ms;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic model_t mreset();
    model_t m;
    m.wr = 0; m.rdy = 1; m.rd = 2; m.valid = 0;
    m.pix = 0; m.drop = 0; m.rep = 0; m.cam_p = 0; m.vga_p = 0;
    return m;
  endfunction

  function automatic model_t step(model_t m, bit cam, bit we, bit vga, int fs);
    model_t n = m;
    int cnt;
    int tmp;
    bit cam_edge = cam && !m.cam_p;
    bit vga_edge = vga && !m.vga_p;
    cnt = m.pix + (we ? 1 : 0);
    if (cnt > fs + 1) cnt = fs + 1;
    if (vga_edge) begin
      if (m.valid) begin
        tmp = n.rd; n.rd = n.rdy; n.rdy = tmp; n.valid = 0;
      end else if (n.rep < 65535) begin
        n.rep = n.rep + 1;
      end
    end
    if (cam_edge) begin
      if (cnt == fs) begin
        n.rdy = m.wr;
        n.valid = 1;
        // writer takes whichever buffer neither reader nor ready slot holds
        for (int b = 0; b < 3; b++)
          if (b != n.rd && b != n.rdy) n.wr = b;
      end else if (cnt != 0 && n.drop < 65535) begin
        n.drop = n.drop + 1;
      end
      n.pix = 0;
    end else begin
      n.pix = cnt;
    end
    n.cam_p = cam;
    n.vga_p = vga;
    return n;
  endfunction

  task automatic chk(string tag, int unsigned obs, int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_b(string tag);
    chk({tag, "_wr"}, wr_b, mb.wr);
    chk({tag, "_rd"}, rd_b, mb.rd);
    chk({tag, "_valid"}, valid_b, mb.valid);
    chk({tag, "_wrbase"}, wrbase_b, mb.wr * FS_B);
    chk({tag, "_rdbase"}, rdbase_b, mb.rd * FS_B);
    chk({tag, "_drop"}, drop_b, mb.drop);
    chk({tag, "_rep"}, rep_b, mb.rep);
    $display("txn %s: wr=%0d rd=%0d valid=%0d drop=%0d rep=%0d", tag, wr_b, rd_b, valid_b, drop_b, rep_b);
  endtask

  task automatic check_s(string tag);
    chk({tag, "_wr"}, wr_s, ms.wr);
    chk({tag, "_rd"}, rd_s, ms.rd);
    chk({tag, "_valid"}, valid_s, ms.valid);
    chk({tag, "_wrbase"}, wrbase_s, ms.wr * FS_S);
    chk({tag, "_rdbase"}, rdbase_s, ms.rd * FS_S);
    chk({tag, "_drop"}, drop_s, ms.drop);
    chk({tag, "_rep"}, rep_s, ms.rep);
  endtask

  task automatic big_cyc(bit cam, bit we, bit vga);
    cam_b = cam; we_b = we; vga_b = vga;
    @(posedge clk);
    mb = step(mb, cam, we, vga, FS_B);
    #1;
  endtask

  task automatic big_frame(int n);
    repeat (n) big_cyc(1'b0, 1'b1, 1'b0);
    big_cyc(1'b1, 1'b0, 1'b0);
    big_cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic small_cyc(bit cam, bit we, bit vga);
    cam_s = cam; we_s = we; vga_s = vga;
    @(posedge clk);
    ms = step(ms, cam, we, vga, FS_S);
    #1;
    check_s("s");
  endtask

  function automatic bit rand_vga();
    return ($urandom_range(0, 4) == 0);
  endfunction

  task automatic small_frame(int len, bit coincide, bit force_vga);
    for (int i = 0; i < len - (coincide ? 1 : 0); i++) begin
      while ($urandom_range(0, 3) == 0) small_cyc(1'b0, 1'b0, rand_vga());
      small_cyc(1'b0, 1'b1, rand_vga());
    end
    if (force_vga) small_cyc(1'b0, 1'b0, 1'b0);
    small_cyc(1'b1, coincide, force_vga ? 1'b1 : rand_vga());
    small_cyc(1'($urandom_range(0, 1)), 1'b0, rand_vga());
    small_cyc(1'b0, 1'b0, rand_vga());
    $display("txn small_frame len=%0d coin=%0d vga=%0d: wr=%0d rd=%0d valid=%0d drop=%0d rep=%0d",
             len, coincide, force_vga, wr_s, rd_s, valid_s, drop_s, rep_s);
  endtask

  initial begin
    int lens[8] = '{12, 12, 12, 11, 13, 14, 0, 5};
    rst_b = 1'b1; cam_b = 1'b0; we_b = 1'b0; vga_b = 1'b0;
    rst_s = 1'b1; cam_s = 1'b0; we_s = 1'b0; vga_s = 1'b0;
    mb = mreset();
    ms = mreset();
    #2;
    check_b("rst");
    chk("rst_rd_lit", rd_b, 2);
    chk("rst_rdbase_lit", rdbase_b, 2 * FS_B);
    check_s("rst_s");
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    rst_s = 1'b0;

    // ---- full-size directed scenarios ----
    big_frame(FS_B);
    check_b("f1");
    chk("f1_valid_lit", valid_b, 1);
    chk("f1_rd_lit", rd_b, 2);

    big_cyc(1'b0, 1'b0, 1'b1);
    check_b("vga1");
    chk("vga1_rd_lit", rd_b, 0);
    chk("vga1_rdbase_lit", rdbase_b, 0);
    big_cyc(1'b0, 1'b0, 1'b0);

    big_frame(100);
    check_b("partial");
    chk("partial_drop_lit", drop_b, 1);

    big_cyc(1'b0, 1'b0, 1'b1);
    check_b("vga_repeat");
    chk("vga_repeat_lit", rep_b, 1);
    big_cyc(1'b0, 1'b0, 1'b0);

    big_frame(FS_B);
    check_b("f2");
    big_frame(FS_B);
    check_b("f3_overwrite");
    chk("f3_distinct", (wr_b != rd_b) ? 1 : 0, 1);

    // ---- small-frame: directed simultaneous cam+vga ----
    repeat (FS_S) small_cyc(1'b0, 1'b1, 1'b0);
    small_cyc(1'b1, 1'b0, 1'b0);
    small_cyc(1'b0, 1'b0, 1'b0);
    repeat (FS_S - 1) small_cyc(1'b0, 1'b1, 1'b0);
    small_cyc(1'b1, 1'b1, 1'b1);
    chk("simul_rd_lit", rd_s, 0);
    chk("simul_wr_lit", wr_s, 2);
    chk("simul_valid_lit", valid_s, 1);
    $display("txn simultaneous: wr=%0d rd=%0d valid=%0d", wr_s, rd_s, valid_s);
    small_cyc(1'b0, 1'b0, 1'b0);

    // ---- small-frame: randomized frames with a mid-frame reset ----
    for (int f = 0; f < 40; f++) begin
      if (f == 20) begin
        repeat (5) small_cyc(1'b0, 1'b1, 1'b0);
        rst_s = 1'b1;
        cam_s = 1'b0; we_s = 1'b0; vga_s = 1'b0;
        #1;
        ms = mreset();
        check_s("midreset");
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        $display("txn mid-frame reset: wr=%0d rd=%0d valid=%0d drop=%0d", wr_s, rd_s, valid_s, drop_s);
      end
      small_frame(lens[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
